// File: rtl/jamma_pkg.sv
// Shared types and constants for the JAMMA joystick reader: FSM states,
// bus widths, bus bit positions and the packed debounce payload.
package jamma_pkg;

  localparam int unsigned JOY_W  = 8;
  localparam int unsigned COIN_W = 2;

  localparam logic [JOY_W-1:0] JOY_IDLE = 8'hFF;

  localparam int unsigned BIT_UP    = 0;
  localparam int unsigned BIT_DOWN  = 1;
  localparam int unsigned BIT_LEFT  = 2;
  localparam int unsigned BIT_RIGHT = 3;
  localparam int unsigned BIT_FIRE1 = 4;
  localparam int unsigned BIT_FIRE2 = 5;
  localparam int unsigned BIT_COIN  = 6;
  localparam int unsigned BIT_START = 7;

  typedef enum logic [2:0] {
    SETTLE_P1,
    SAMPLE_P1,
    SETTLE_P2,
    SAMPLE_P2,
    EVAL
  } state_e;

  // One frame's worth of sampled inputs, debounced as a single vector.
  typedef struct packed {
    logic [COIN_W-1:0] coin;
    logic [JOY_W-1:0]  p2;
    logic [JOY_W-1:0]  p1;
  } deb_vec_t;

  localparam int unsigned DEB_W = $bits(deb_vec_t);

endpackage

// File: rtl/jamma_joy_reader_if.sv
// Bus-side signal bundle of the joystick reader: shared JJOY input, mux
// select and the debounced player/coin images.
interface jamma_joy_reader_if;
  import jamma_pkg::*;

  logic [JOY_W-1:0]  jjoy_i;
  logic [COIN_W-1:0] jcoin_i;
  logic              jsel_o;
  logic [JOY_W-1:0]  joy1_o;
  logic [JOY_W-1:0]  joy2_o;
  logic [COIN_W-1:0] coin_o;
  logic              upd_o;

  modport slave  (input  jjoy_i, jcoin_i, output jsel_o, joy1_o, joy2_o, coin_o, upd_o);
  modport master (output jjoy_i, jcoin_i, input  jsel_o, joy1_o, joy2_o, coin_o, upd_o);

endinterface

// File: rtl/jamma_deb_vec.sv
// Per-bit frame debouncer: a bit's stable value flips only after FRAMES
// consecutive step strobes that disagree with it.
module jamma_deb_vec #(
  parameter int unsigned W      = 18,
  parameter int unsigned FRAMES = 4
) (
  input  logic         clk_i,
  input  logic         res_n_i,
  input  logic         step_i,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o
);

  localparam int unsigned       CNT_W = 4;
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(FRAMES - 1);

  logic [W-1:0]            stable_q, stable_d;
  logic [W-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      stable_q <= '1;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (step_i) begin
      for (int unsigned i = 0; i < W; i++) begin
        if (raw_i[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == LIMIT) begin
          stable_d[i] = raw_i[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/jamma_joy_reader.sv
// Time-multiplexed JAMMA joystick reader with settle delay and frame debounce.
// Optional coin pulse stretching is enabled with `define JAMMA_COIN_STRETCH_EN.
module jamma_joy_reader
  import jamma_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES    = 24,
  parameter int unsigned DEBOUNCE_FRAMES  = 4,
  parameter int unsigned COIN_HOLD_FRAMES = 8
) (
  input  logic               clk_i,
  input  logic               res_n_i,
  jamma_joy_reader_if.slave  jj
);

  localparam int unsigned      CNT_W       = 8;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // Elaboration-time range checks on the configuration.
  if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES out of range 1..255");
  end
  if (DEBOUNCE_FRAMES == 0 || DEBOUNCE_FRAMES > 15) begin : g_bad_deb
    $error("DEBOUNCE_FRAMES out of range 1..15");
  end
  if (COIN_HOLD_FRAMES == 0 || COIN_HOLD_FRAMES > 255) begin : g_bad_hold
    $error("COIN_HOLD_FRAMES out of range 1..255");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             jsel_q, jsel_d;
  logic             upd_q, upd_d;
  deb_vec_t         raw_q, raw_d;
  deb_vec_t         stable;

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      state_q <= SETTLE_P1;
      cnt_q   <= '0;
      jsel_q  <= 1'b0;
      upd_q   <= 1'b0;
      raw_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      jsel_q  <= jsel_d;
      upd_q   <= upd_d;
      raw_q   <= raw_d;
    end
  end

  // Frame sequencer; select and strobe are registered from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    unique case (state_q)
      SETTLE_P1, SETTLE_P2: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == SETTLE_P1) ? SAMPLE_P1 : SAMPLE_P2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE_P1: begin
        raw_d.p1   = jj.jjoy_i;
        raw_d.coin = jj.jcoin_i;
        state_d    = SETTLE_P2;
      end
      SAMPLE_P2: begin
        raw_d.p2 = jj.jjoy_i;
        state_d  = EVAL;
      end
      EVAL:    state_d = SETTLE_P1;
      default: state_d = SETTLE_P1;
    endcase
    jsel_d = (state_d == SETTLE_P2) || (state_d == SAMPLE_P2) || (state_d == EVAL);
    upd_d  = (state_d == EVAL);
  end

  jamma_deb_vec #(
    .W      (DEB_W),
    .FRAMES (DEBOUNCE_FRAMES)
  ) u_deb (
    .clk_i    (clk_i),
    .res_n_i  (res_n_i),
    .step_i   (state_q == EVAL),
    .raw_i    (raw_q),
    .stable_o (stable)
  );

  assign jj.jsel_o = jsel_q;
  assign jj.upd_o  = upd_q;

`ifdef JAMMA_COIN_STRETCH_EN
  localparam int unsigned STR_N  = 4;
  localparam int unsigned HOLD_W = 8;

  logic                         post_q;
  logic [STR_N-1:0]             prev_q, prev_d;
  logic [STR_N-1:0]             out_q, out_d;
  logic [STR_N-1:0][HOLD_W-1:0] hold_q, hold_d;
  logic [STR_N-1:0]             str_in;
  logic [JOY_W-1:0]             joy1_c, joy2_c;

  assign str_in = {stable.coin, stable.p2[BIT_COIN], stable.p1[BIT_COIN]};

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      post_q <= 1'b0;
      prev_q <= '1;
      out_q  <= '1;
      hold_q <= '0;
    end else begin
      post_q <= (state_q == EVAL);
      prev_q <= prev_d;
      out_q  <= out_d;
      hold_q <= hold_d;
    end
  end

  // Runs the cycle after EVAL, once the fresh stable values are visible.
  always_comb begin
    prev_d = prev_q;
    out_d  = out_q;
    hold_d = hold_q;
    if (post_q) begin
      for (int unsigned i = 0; i < STR_N; i++) begin
        prev_d[i] = str_in[i];
        if (prev_q[i] && !str_in[i]) begin
          hold_d[i] = HOLD_W'(COIN_HOLD_FRAMES);
        end else if (hold_q[i] != '0) begin
          hold_d[i] = hold_q[i] - HOLD_W'(1);
        end
        out_d[i] = (hold_d[i] == '0) && str_in[i];
      end
    end
  end

  always_comb begin
    joy1_c           = stable.p1;
    joy1_c[BIT_COIN] = out_q[0];
    joy2_c           = stable.p2;
    joy2_c[BIT_COIN] = out_q[1];
  end

  assign jj.joy1_o = joy1_c;
  assign jj.joy2_o = joy2_c;
  assign jj.coin_o = out_q[3:2];
`else
  assign jj.joy1_o = stable.p1;
  assign jj.joy2_o = stable.p2;
  assign jj.coin_o = stable.coin;
`endif

endmodule

// File: tb/tb_jamma_joy_reader.sv
// Bench for jamma_joy_reader: emulates the external player mux, runs directed
// and random frames, and compares against a sample-history debounce model.
module tb_jamma_joy_reader;
  import jamma_pkg::*;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned DEB    = 3;
  localparam int unsigned HOLD   = 8;
  localparam int          FRAME  = 2 * SETTLE + 3;

  logic clk   = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  jamma_joy_reader_if jif ();

  jamma_joy_reader #(
    .SETTLE_CYCLES    (SETTLE),
    .DEBOUNCE_FRAMES  (DEB),
    .COIN_HOLD_FRAMES (HOLD)
  ) dut (
    .clk_i   (clk),
    .res_n_i (res_n),
    .jj      (jif)
  );

  logic [7:0] p1, p2;
  logic [1:0] cn;
  logic       glitch;

  // External 2:1 player mux, plus a bus-wide glitch source.
  always_comb begin
    jif.jjoy_i  = glitch ? 8'h00 : (jif.jsel_o ? p2 : p1);
    jif.jcoin_i = glitch ? 2'b00 : cn;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a bit flips once its last DEB frame samples all oppose it.
  logic [17:0] hist [DEB];
  logic [17:0] m_stable;
  logic [17:0] m_out;
  int          eval_n;
  int          fall_at [4];
  int          str_idx [4] = '{6, 14, 16, 17};

  task automatic model_reset();
    for (int i = 0; i < DEB; i++) hist[i] = '1;
    m_stable = '1;
    m_out    = '1;
    eval_n   = 0;
    for (int j = 0; j < 4; j++) fall_at[j] = -1000;
  endtask

  task automatic model_eval(input logic [17:0] s);
    logic [17:0] acc, prev;
    for (int i = DEB - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    acc = '1;
    for (int i = 0; i < DEB; i++) acc &= hist[i] ^ m_stable;
    prev     = m_stable;
    m_stable = m_stable ^ acc;
    m_out    = m_stable;
`ifdef JAMMA_COIN_STRETCH_EN
    for (int j = 0; j < 4; j++) begin
      if (prev[str_idx[j]] && !m_stable[str_idx[j]]) fall_at[j] = eval_n;
      if (eval_n - fall_at[j] < HOLD) m_out[str_idx[j]] = 1'b0;
    end
`else
    if (prev == '0) m_out = m_stable;
`endif
    eval_n++;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_jsel"}, 32'(jif.jsel_o), 32'(0));
    chk({tag, "_upd"},  32'(jif.upd_o),  32'(0));
    chk({tag, "_joy1"}, 32'(jif.joy1_o), 32'(8'hFF));
    chk({tag, "_joy2"}, 32'(jif.joy2_o), 32'(8'hFF));
    chk({tag, "_coin"}, 32'(jif.coin_o), 32'(2'b11));
  endtask

  // One frame starting at its first SETTLE_P1 cycle; abort_at >= 0 pulses reset there.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c,
                           input bit g, input int abort_at);
    p1 = a;
    p2 = b;
    cn = c;
    for (int fc = 0; fc < FRAME; fc++) begin
      glitch = g && ((fc <= 2) || (fc >= 5 && fc <= 7));
      chk("jsel", 32'(jif.jsel_o), 32'(fc >= int'(SETTLE) + 1));
      chk("upd",  32'(jif.upd_o),  32'(fc == FRAME - 1));
      if (fc == FRAME - 1) begin
        chk("joy1", 32'(jif.joy1_o), 32'(m_out[7:0]));
        chk("joy2", 32'(jif.joy2_o), 32'(m_out[15:8]));
        chk("coin", 32'(jif.coin_o), 32'(m_out[17:16]));
        model_eval({c, b, a});
      end
      if (fc == abort_at) begin
        res_n = 1'b0;
        @(posedge clk); #1;
        res_n  = 1'b1;
        glitch = 1'b0;
        model_reset();
        check_reset("midreset");
        return;
      end
      @(posedge clk); #1;
    end
    glitch = 1'b0;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] rc;
    p1 = 8'hFF; p2 = 8'hFF; cn = 2'b11; glitch = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 res_n = 1'b1;
    check_reset("reset");

    repeat (3) run_frame(8'hFF, 8'hFF, 2'b11, 1'b0, -1);

    // Player 1 fire1, then reset in the middle of SETTLE_P2.
    repeat (3) run_frame(8'hEF, 8'hFF, 2'b11, 1'b0, -1);
    chk("fire1_direct", 32'(jif.joy1_o), 32'(8'hEF));
    run_frame(8'hEF, 8'hFF, 2'b11, 1'b0, 6);

    // Glitches only outside sample states.
    repeat (4) run_frame(8'hFF, 8'hFF, 2'b11, 1'b1, -1);

    // Short then qualifying coin press.
    repeat (2) run_frame(8'hFF, 8'hFF, 2'b10, 1'b0, -1);
    repeat (3) run_frame(8'hFF, 8'hFF, 2'b11, 1'b0, -1);
    repeat (3) run_frame(8'hFF, 8'hFF, 2'b10, 1'b0, -1);
    repeat (11) run_frame(8'hFF, 8'hFF, 2'b11, 1'b0, -1);

    // Bus coin on both players, then simultaneous multi-bit changes.
    repeat (3) run_frame(8'hBF, 8'hBF, 2'b01, 1'b0, -1);
    repeat (11) run_frame(8'h5A, 8'hA5, 2'b11, 1'b0, -1);

    ra = 8'hFF; rb = 8'hFF; rc = 2'b11;
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(3) == 0) ra = 8'($urandom);
      if ($urandom_range(3) == 0) rb = 8'($urandom);
      if ($urandom_range(3) == 0) rc = 2'($urandom);
      run_frame(ra, rb, rc, ($urandom_range(2) == 0), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
